edge_window_ctrl: RTL and testbench

//  Line-buffer scheduler for the 3x3 edge-detection datapath. Tracks raster position from HDMI de/hsync/vsync.

---
 rtl/edge_pkg.sv | 35 +++
 rtl/edge_window_ctrl_sync_delay.sv | 40 ++++
 rtl/edge_window_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_edge_window_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the 3x3 edge-detection line-buffer scheduler:
//   - state_t : controller FSM states
//   - rot3()  : modulo-3 rotation used for line-buffer select arithmetic
//   - 1080p blanking constants describing the HDMI timing the block expects
// -----------------------------------------------------------------------------
package edge_pkg;

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_BLANK = 2'd1,
        S_LINE  = 2'd2
    } state_t;

    // 1080p60 blanking intervals (pixels / lines)
    localparam int H_FRONT = 88;
    localparam int H_SYNC  = 44;
    localparam int H_BACK  = 148;
    localparam int V_FRONT = 4;
    localparam int V_SYNC  = 5;
    localparam int V_BACK  = 36;

    // (sel + step) mod 3 for sel in 0..2, step in 0..2
    function automatic logic [1:0] rot3(input logic [1:0] sel, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, sel} + {1'b0, step};
        if (sum >= 3'd3) begin
            return 2'(sum - 3'd3);
        end else begin
            return sum[1:0];
        end
    endfunction

endpackage

// File: rtl/edge_window_ctrl_sync_delay.sv
// -----------------------------------------------------------------------------
// sync_delay
// Fixed-depth shift register that re-times the HDMI control bits so they line
// up with the pixel datapath output. Purely a delay line, no qualification.
// Ports:
//   clk      in   pixel clock
//   reset_n  in   asynchronous active-low reset (stages load RST_VAL)
//   din      in   W-bit control word
//   dout     out  din delayed by DEPTH clocks (last stage, registered)
// -----------------------------------------------------------------------------
module sync_delay #(
    parameter int             DEPTH   = 4,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_r [DEPTH];

    // Shift chain: stage 0 samples din, each later stage takes its predecessor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RST_VAL;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/edge_window_ctrl.sv
// -----------------------------------------------------------------------------
// edge_window_ctrl
// Line-buffer scheduler for the 3x3 edge-detection kernel. Follows the raster
// position from HDMI de/vsync, rotates three line-buffer RAMs (one written,
// two read), and produces window qualifiers plus latency-matched syncs.
// Ports:
//   clk, reset_n                  pixel clock, async active-low reset
//   hdmi_de/hsync/vsync           incoming video timing (syncs active low)
//   lb_wr_en/lb_wr_sel/lb_addr    line-buffer write strobe, target buffer, column
//   lb_rd_sel_a/lb_rd_sel_b       buffers holding rows y-2 / y-1
//   win_valid/win_border          window column valid, window incomplete
//   pix_x/pix_y                   position of the pixel being written
//   edge_de/hsync/vsync           timing delayed PIPE_LAT clocks
//   line_err/frame_err            sticky geometry errors, cleared at frame start
// -----------------------------------------------------------------------------
module edge_window_ctrl
    import edge_pkg::*;
#(
    parameter int H_ACT    = 1920,
    parameter int V_ACT    = 1080,
    parameter int PIPE_LAT = 4,
    parameter int X_W      = $clog2(H_ACT),
    parameter int Y_W      = $clog2(V_ACT)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           hdmi_de,
    input  logic           hdmi_hsync,
    input  logic           hdmi_vsync,
    output logic           lb_wr_en,
    output logic [1:0]     lb_wr_sel,
    output logic [X_W-1:0] lb_addr,
    output logic [1:0]     lb_rd_sel_a,
    output logic [1:0]     lb_rd_sel_b,
    output logic           win_valid,
    output logic           win_border,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           edge_de,
    output logic           edge_hsync,
    output logic           edge_vsync,
    output logic           line_err,
    output logic           frame_err
);

    // The pixel counter is one bit wider than the address so it can reach
    // H_ACT (normal line end) and H_ACT+1 (over-long line marker).
    localparam logic [X_W:0]   H_ACT_C  = (X_W+1)'(H_ACT);
    localparam logic [X_W:0]   H_SAT_C  = (X_W+1)'(H_ACT + 1);
    localparam logic [Y_W:0]   V_ACT_C  = (Y_W+1)'(V_ACT);
    localparam logic [Y_W-1:0] Y_LAST_C = Y_W'(V_ACT - 1);

    state_t         state_r;
    state_t         state_nxt_s;
    logic           vs_prev_r;
    logic           frame_start_s;
    logic [X_W:0]   x_cnt_r;
    logic [X_W:0]   x_cur_s;
    logic [Y_W-1:0] y_r;
    logic [Y_W:0]   lines_r;
    logic [1:0]     wr_sel_r;
    logic           pix_go_s;
    logic           wr_go_s;
    logic           line_start_s;
    logic           line_end_s;
    logic [2:0]     sync_out_s;

    assign frame_start_s = vs_prev_r & ~hdmi_vsync;
    // Only the first H_ACT pixels of a line reach the RAM.
    assign wr_go_s       = pix_go_s & (x_cur_s < H_ACT_C);

    // Previous vsync level for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_r <= 1'b1;
        end else begin
            vs_prev_r <= hdmi_vsync;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; frame start overrides everything, including a live line.
    always_comb begin
        state_nxt_s = state_r;
        if (frame_start_s) begin
            state_nxt_s = S_BLANK;
        end else begin
            case (state_r)
                S_SYNC:  state_nxt_s = S_SYNC;
                S_BLANK: state_nxt_s = hdmi_de ? S_LINE : S_BLANK;
                S_LINE:  state_nxt_s = hdmi_de ? S_LINE : S_BLANK;
                default: state_nxt_s = S_SYNC;
            endcase
        end
    end

    // FSM decode: which pixel (if any) this cycle carries and line boundaries.
    // The de=1 cycle seen in S_BLANK is column 0 of the new line.
    always_comb begin
        pix_go_s     = 1'b0;
        line_start_s = 1'b0;
        line_end_s   = 1'b0;
        x_cur_s      = x_cnt_r;
        case (state_r)
            S_BLANK: begin
                x_cur_s      = '0;
                pix_go_s     = hdmi_de & ~frame_start_s;
                line_start_s = hdmi_de & ~frame_start_s;
            end
            S_LINE: begin
                pix_go_s   = hdmi_de & ~frame_start_s;
                line_end_s = ~hdmi_de & ~frame_start_s;
            end
            default: begin
                pix_go_s = 1'b0;
            end
        endcase
    end

    // Raster position, completed-line count and write-buffer rotation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt_r  <= '0;
            y_r      <= '0;
            lines_r  <= '0;
            wr_sel_r <= 2'd0;
        end else if (frame_start_s) begin
            x_cnt_r  <= '0;
            y_r      <= '0;
            lines_r  <= '0;
            wr_sel_r <= 2'd0;
        end else begin
            if (pix_go_s) begin
                x_cnt_r <= (x_cur_s >= H_SAT_C) ? H_SAT_C : x_cur_s + (X_W+1)'(1);
            end
            if (line_end_s) begin
                wr_sel_r <= rot3(wr_sel_r, 2'd1);
                y_r      <= (y_r == Y_LAST_C) ? y_r : y_r + Y_W'(1);
                lines_r  <= (lines_r == V_ACT_C) ? lines_r : lines_r + (Y_W+1)'(1);
            end
        end
    end

    // Sticky error flags; cleared only by a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else if (frame_start_s) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (line_end_s && (x_cnt_r != H_ACT_C)) begin
                line_err <= 1'b1;
            end
            if (line_start_s && (lines_r == V_ACT_C)) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Line-buffer port: address/selects only move on a write so the last
    // written pixel stays visible (x holds at H_ACT-1 on over-long lines).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lb_wr_en    <= 1'b0;
            lb_wr_sel   <= 2'd0;
            lb_addr     <= '0;
            lb_rd_sel_a <= 2'd0;
            lb_rd_sel_b <= 2'd0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            lb_wr_en <= wr_go_s;
            if (wr_go_s) begin
                lb_wr_sel   <= wr_sel_r;
                lb_addr     <= x_cur_s[X_W-1:0];
                lb_rd_sel_a <= rot3(wr_sel_r, 2'd1);
                lb_rd_sel_b <= rot3(wr_sel_r, 2'd2);
                pix_x       <= x_cur_s[X_W-1:0];
                pix_y       <= y_r;
            end
        end
    end

    // Window qualifiers follow the write by one clock (RAM read latency);
    // border is evaluated on the pixel that was just written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_valid  <= 1'b0;
            win_border <= 1'b0;
        end else begin
            win_valid  <= lb_wr_en;
            win_border <= lb_wr_en & ((pix_y < Y_W'(2)) | (pix_x < X_W'(2)));
        end
    end

    sync_delay #(
        .DEPTH   (PIPE_LAT),
        .W       (3),
        .RST_VAL (3'b011)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({hdmi_de, hdmi_hsync, hdmi_vsync}),
        .dout    (sync_out_s)
    );

    assign edge_de    = sync_out_s[2];
    assign edge_hsync = sync_out_s[1];
    assign edge_vsync = sync_out_s[0];

endmodule

// File: tb/tb_edge_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_edge_window_ctrl
// Directed bench for edge_window_ctrl at H_ACT=8, V_ACT=4, PIPE_LAT=4.
// A per-line table drives the main frame sequences; hand-written sequences
// cover pre-vsync de, mid-line frame start and mid-line reset.
// -----------------------------------------------------------------------------
module tb_edge_window_ctrl;

    localparam int H_ACT    = 8;
    localparam int V_ACT    = 4;
    localparam int PIPE_LAT = 4;
    localparam int X_W      = $clog2(H_ACT);
    localparam int Y_W      = $clog2(V_ACT);
    localparam int HD       = PIPE_LAT - 1;

    logic           clk        = 1'b0;
    logic           reset_n    = 1'b0;
    logic           hdmi_de    = 1'b0;
    logic           hdmi_hsync = 1'b1;
    logic           hdmi_vsync = 1'b1;
    logic           lb_wr_en;
    logic [1:0]     lb_wr_sel;
    logic [X_W-1:0] lb_addr;
    logic [1:0]     lb_rd_sel_a;
    logic [1:0]     lb_rd_sel_b;
    logic           win_valid;
    logic           win_border;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           edge_de;
    logic           edge_hsync;
    logic           edge_vsync;
    logic           line_err;
    logic           frame_err;

    int n_vec    = 0;
    int n_err    = 0;
    int wv_count = 0;

    // Inputs applied on the previous HD cycles, newest at index 0.
    logic h_de [HD];
    logic h_hs [HD];
    logic h_vs [HD];

    typedef struct {
        bit             new_frame;
        int             len;
        logic [1:0]     sel;
        logic [1:0]     rd_a;
        logic [1:0]     rd_b;
        logic [Y_W-1:0] y;
        logic           lerr;
        logic           ferr;
    } line_vec_t;

    line_vec_t tbl [8];

    edge_window_ctrl #(
        .H_ACT    (H_ACT),
        .V_ACT    (V_ACT),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hdmi_de     (hdmi_de),
        .hdmi_hsync  (hdmi_hsync),
        .hdmi_vsync  (hdmi_vsync),
        .lb_wr_en    (lb_wr_en),
        .lb_wr_sel   (lb_wr_sel),
        .lb_addr     (lb_addr),
        .lb_rd_sel_a (lb_rd_sel_a),
        .lb_rd_sel_b (lb_rd_sel_b),
        .win_valid   (win_valid),
        .win_border  (win_border),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .edge_de     (edge_de),
        .edge_hsync  (edge_hsync),
        .edge_vsync  (edge_vsync),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic hist_idle();
        for (int i = 0; i < HD; i++) begin
            h_de[i] = 1'b0;
            h_hs[i] = 1'b1;
            h_vs[i] = 1'b1;
        end
    endtask

    // Apply one input set, clock once, then check the delayed syncs.
    task automatic cyc(input logic de, input logic hs, input logic vs);
        logic e_de, e_hs, e_vs;
        hdmi_de    = de;
        hdmi_hsync = hs;
        hdmi_vsync = vs;
        e_de = h_de[HD-1];
        e_hs = h_hs[HD-1];
        e_vs = h_vs[HD-1];
        for (int i = HD - 1; i > 0; i--) begin
            h_de[i] = h_de[i-1];
            h_hs[i] = h_hs[i-1];
            h_vs[i] = h_vs[i-1];
        end
        h_de[0] = de;
        h_hs[0] = hs;
        h_vs[0] = vs;
        @(posedge clk);
        #1;
        chk("edge_de",    32'(edge_de),    32'(e_de));
        chk("edge_hsync", 32'(edge_hsync), 32'(e_hs));
        chk("edge_vsync", 32'(edge_vsync), 32'(e_vs));
        if (win_valid) wv_count++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"},     32'(lb_wr_en),    32'd0);
        chk({tag, "_wr_sel"},    32'(lb_wr_sel),   32'd0);
        chk({tag, "_addr"},      32'(lb_addr),     32'd0);
        chk({tag, "_rd_a"},      32'(lb_rd_sel_a), 32'd0);
        chk({tag, "_rd_b"},      32'(lb_rd_sel_b), 32'd0);
        chk({tag, "_win_valid"}, 32'(win_valid),   32'd0);
        chk({tag, "_border"},    32'(win_border),  32'd0);
        chk({tag, "_pix_x"},     32'(pix_x),       32'd0);
        chk({tag, "_pix_y"},     32'(pix_y),       32'd0);
        chk({tag, "_edge_de"},   32'(edge_de),     32'd0);
        chk({tag, "_edge_hs"},   32'(edge_hsync),  32'd1);
        chk({tag, "_edge_vs"},   32'(edge_vsync),  32'd1);
        chk({tag, "_line_err"},  32'(line_err),    32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err),   32'd0);
    endtask

    task automatic vsync_pulse();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
    endtask

    // One de pulse of len cycles followed by a 4-cycle blank with an hsync pulse.
    task automatic run_line(input int len, input logic [1:0] sel, input logic [1:0] ra,
                            input logic [1:0] rb, input logic [Y_W-1:0] y);
        wv_count = 0;
        for (int k = 0; k < len; k++) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("wr_en", 32'(lb_wr_en), 32'(k < H_ACT));
            if (k < H_ACT) begin
                chk("addr",   32'(lb_addr),     32'(k));
                chk("pix_x",  32'(pix_x),       32'(k));
                chk("pix_y",  32'(pix_y),       32'(y));
                chk("wr_sel", 32'(lb_wr_sel),   32'(sel));
                chk("rd_a",   32'(lb_rd_sel_a), 32'(ra));
                chk("rd_b",   32'(lb_rd_sel_b), 32'(rb));
            end else begin
                chk("pix_x_sat", 32'(pix_x), 32'(H_ACT - 1));
            end
            chk("win_valid",  32'(win_valid),
                32'((k > 0) && (k - 1 < H_ACT)));
            chk("win_border", 32'(win_border),
                32'((k > 0) && (k - 1 < H_ACT) && ((y < 2) || (k - 1 < 2))));
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, (k == 1 || k == 2) ? 1'b0 : 1'b1, 1'b1);
            chk("blank_wr_en", 32'(lb_wr_en), 32'd0);
            if (k == 0) begin
                chk("last_win_valid", 32'(win_valid), 32'(len - 1 < H_ACT));
            end
        end
        chk("win_valid_count", 32'(wv_count), 32'(H_ACT));
    endtask

    initial begin
        tbl[0] = '{1'b1,  8, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0,  8, 2'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b0,  8, 2'd2, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0};
        tbl[3] = '{1'b0,  8, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0};
        tbl[4] = '{1'b0,  8, 2'd1, 2'd2, 2'd0, 2'd3, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 10, 2'd0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0};
        tbl[6] = '{1'b0,  8, 2'd1, 2'd2, 2'd0, 2'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b1,  8, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0};

        hist_idle();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;

        // de before any vsync: nothing written, syncs still delayed.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("pre_vs_wr_en", 32'(lb_wr_en), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk("pre_vs_wr_en", 32'(lb_wr_en), 32'd0);
        end

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].new_frame) begin
                vsync_pulse();
                chk("fs_line_err",  32'(line_err),  32'd0);
                chk("fs_frame_err", 32'(frame_err), 32'd0);
            end
            run_line(tbl[i].len, tbl[i].sel, tbl[i].rd_a, tbl[i].rd_b, tbl[i].y);
            chk("line_err",  32'(line_err),  32'(tbl[i].lerr));
            chk("frame_err", 32'(frame_err), 32'(tbl[i].ferr));
        end

        // Frame start mid-line (x=3): line aborted, new line restarts at buffer 0.
        vsync_pulse();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("ab_addr", 32'(lb_addr), 32'(k));
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk("ab_wr_en", 32'(lb_wr_en), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("ab_restart_wr_en", 32'(lb_wr_en),  32'd1);
        chk("ab_restart_addr",  32'(lb_addr),   32'd0);
        chk("ab_restart_sel",   32'(lb_wr_sel), 32'd0);
        chk("ab_restart_y",     32'(pix_y),     32'd0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("ab_next_addr", 32'(lb_addr), 32'd1);

        // Asynchronous reset in the middle of the line.
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        hist_idle();
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("post_rst_wr_en", 32'(lb_wr_en), 32'd0);
            chk("post_rst_addr",  32'(lb_addr),  32'd0);
        end
        cyc(1'b0, 1'b1, 1'b1);
        chk("post_rst_line_err", 32'(line_err), 32'd0);

        // Recovery: next vsync fall restarts normal scheduling.
        vsync_pulse();
        run_line(8, 2'd0, 2'd1, 2'd2, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
